// File: rtl/pixel_layer_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_layer_arbiter
//
// Purpose:
//   Two-stage pixel compositor for a tile/sprite game screen. Each accepted
//   pixel carries six 4-bit palette indices (five sprite layers plus the
//   background). In play mode the first opaque sprite in fixed priority
//   order wins, otherwise the background is shown. In the three full-screen
//   modes (initial, game over, you win) the splash image index is shown
//   instead. The screen mode only changes on a frame boundary.
//
//   Optional collision detection (character touching a monster or bullet)
//   is built only when the macro PIXEL_LAYER_ARBITER_COLLISION_EN is
//   defined. Without it hit_pulse and hit_count are constant zero.
//
// Parameters:
//   TRANSPARENT_IDX  palette index treated as transparent on every sprite
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous active-high reset
//   pix_valid    in   layer indices for one pixel presented this cycle
//   frame_start  in   pulse on the first pixel cycle of a frame
//   layer_idx    in   6 x 4-bit indices, layer k at [4k+3:4k]
//                     (0 heart, 1 bullet, 2 key, 3 monster, 4 character,
//                      5 background)
//   layer_en     in   per-layer enable, bit 5 ignored
//   splash_idx   in   full-screen image palette index
//   screen_req   in   requested screen: 0 play, 1 initial, 2 gameover, 3 youwin
//   out_valid    out  result valid, two cycles after pix_valid
//   out_layer    out  selected palette: 0-5 layer ids, 6 splash
//   out_index    out  index into the selected palette
//   out_screen   out  screen mode in effect for this pixel
//   hit_pulse    out  overlap detected on this output pixel
//   hit_count    out  overlaps counted in the current frame (saturating)
// -----------------------------------------------------------------------------
module pixel_layer_arbiter #(
   parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        pix_valid,
   input  logic        frame_start,
   input  logic [23:0] layer_idx,
   input  logic [5:0]  layer_en,
   input  logic [4:0]  splash_idx,
   input  logic [1:0]  screen_req,
   output logic        out_valid,
   output logic [2:0]  out_layer,
   output logic [4:0]  out_index,
   output logic [1:0]  out_screen,
   output logic        hit_pulse,
   output logic [7:0]  hit_count
);

   // Screen-mode states; encodings match the screen_req / out_screen codes.
   typedef enum logic [1:0] {
      MODE_PLAY = 2'd0,
      MODE_INIT = 2'd1,
      MODE_OVER = 2'd2,
      MODE_WIN  = 2'd3
   } mode_t;

   localparam logic [2:0] LAYER_BG     = 3'd5;
   localparam logic [2:0] LAYER_SPLASH = 3'd6;
   localparam int         NUM_SPRITES  = 5;

   // ------------------------------------------------------------------
   // Mode FSM
   // ------------------------------------------------------------------
   mode_t mode_q, mode_d;

   always_comb begin
      mode_d = mode_q;
      if (frame_start) begin
         case (screen_req)
            2'd0:    mode_d = MODE_PLAY;
            2'd1:    mode_d = MODE_INIT;
            2'd2:    mode_d = MODE_OVER;
            default: mode_d = MODE_WIN;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mode_q <= MODE_INIT;
      end else begin
         mode_q <= mode_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: capture indices and build the opaque mask
   // ------------------------------------------------------------------
   logic [NUM_SPRITES-1:0] opaque_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_opaque
         assign opaque_d[gi] = layer_en[gi] &&
                               (layer_idx[4*gi +: 4] != TRANSPARENT_IDX);
      end
   endgenerate

   logic                   s1_valid_q,  s1_valid_d;
   logic [23:0]            s1_idx_q,    s1_idx_d;
   logic [4:0]             s1_splash_q, s1_splash_d;
   mode_t                  s1_mode_q,   s1_mode_d;
   logic [NUM_SPRITES-1:0] s1_opaque_q, s1_opaque_d;

   always_comb begin
      s1_valid_d  = pix_valid;
      s1_idx_d    = s1_idx_q;
      s1_splash_d = s1_splash_q;
      s1_mode_d   = s1_mode_q;
      s1_opaque_d = s1_opaque_q;
      if (pix_valid) begin
         s1_idx_d    = layer_idx;
         s1_splash_d = splash_idx;
         // mode_d, not mode_q: a pixel arriving with frame_start already
         // belongs to the new frame's screen.
         s1_mode_d   = mode_d;
         s1_opaque_d = opaque_d;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_valid_q  <= 1'b0;
         s1_idx_q    <= '0;
         s1_splash_q <= '0;
         s1_mode_q   <= MODE_INIT;
         s1_opaque_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_idx_q    <= s1_idx_d;
         s1_splash_q <= s1_splash_d;
         s1_mode_q   <= s1_mode_d;
         s1_opaque_q <= s1_opaque_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: priority select
   // ------------------------------------------------------------------
   logic [2:0] sel_layer;
   logic [4:0] sel_index;

   always_comb begin
      sel_layer = LAYER_BG;
      sel_index = {1'b0, s1_idx_q[23:20]};
      if (s1_mode_q != MODE_PLAY) begin
         sel_layer = LAYER_SPLASH;
         sel_index = s1_splash_q;
      end else begin
         // Walk from lowest to highest priority so the highest-priority
         // opaque layer (lowest id) is the last assignment and wins.
         for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (s1_opaque_q[k]) begin
               sel_layer = k[2:0];
               sel_index = {1'b0, s1_idx_q[4*k +: 4]};
            end
         end
      end
   end

   logic       out_valid_q,  out_valid_d;
   logic [2:0] out_layer_q,  out_layer_d;
   logic [4:0] out_index_q,  out_index_d;
   logic [1:0] out_screen_q, out_screen_d;

   always_comb begin
      out_valid_d  = s1_valid_q;
      out_layer_d  = out_layer_q;
      out_index_d  = out_index_q;
      out_screen_d = out_screen_q;
      if (s1_valid_q) begin
         out_layer_d  = sel_layer;
         out_index_d  = sel_index;
         out_screen_d = s1_mode_q;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         out_valid_q  <= 1'b0;
         out_layer_q  <= LAYER_BG;
         out_index_q  <= '0;
         out_screen_q <= MODE_INIT;
      end else begin
         out_valid_q  <= out_valid_d;
         out_layer_q  <= out_layer_d;
         out_index_q  <= out_index_d;
         out_screen_q <= out_screen_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_layer  = out_layer_q;
   assign out_index  = out_index_q;
   assign out_screen = out_screen_q;

   // ------------------------------------------------------------------
   // Collision detection
   // ------------------------------------------------------------------
`ifdef PIXEL_LAYER_ARBITER_COLLISION_EN
   logic       overlap;
   logic       hit_pulse_q, hit_pulse_d;
   logic [7:0] hit_count_q, hit_count_d;

   // Character (4) touching monster (3) or bullet (1) while playing.
   assign overlap = s1_valid_q && (s1_mode_q == MODE_PLAY) &&
                    s1_opaque_q[4] && (s1_opaque_q[3] || s1_opaque_q[1]);

   always_comb begin
      hit_pulse_d = overlap;
      hit_count_d = hit_count_q;
      if (frame_start) begin
         // The pixel leaving stage 2 on a frame_start edge is counted
         // toward the frame that is starting.
         hit_count_d = overlap ? 8'd1 : 8'd0;
      end else if (overlap && (hit_count_q != 8'hFF)) begin
         hit_count_d = hit_count_q + 8'd1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hit_pulse_q <= 1'b0;
         hit_count_q <= '0;
      end else begin
         hit_pulse_q <= hit_pulse_d;
         hit_count_q <= hit_count_d;
      end
   end

   assign hit_pulse = hit_pulse_q;
   assign hit_count = hit_count_q;
`else
   assign hit_pulse = 1'b0;
   assign hit_count = 8'd0;
`endif

endmodule
